// File: rtl/sha1_digest_writer.sv
// SHA-1 digest writer: captures a 160-bit digest on start and writes it to the
// dpsram as NUM_WORDS 32-bit words, optionally flagging a match against a target.
module sha1_digest_writer #(
  parameter int unsigned NUM_WORDS   = 5,
  parameter bit          SWAP_BYTES  = 1'b1,
  parameter int unsigned ADDR_STRIDE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [32*NUM_WORDS-1:0] hash,
  input  logic [31:0]             output_addr,
  input  logic [32*NUM_WORDS-1:0] target_hash,
  input  logic                    compare_en,
  output logic                    port_A_clk,
  output logic [31:0]             port_A_data_in,
  output logic [15:0]             port_A_addr,
  output logic                    port_A_we,
  output logic                    busy,
  output logic                    done,
  output logic                    match,
  output logic                    overrun
);

  localparam int unsigned HASH_W = 32 * NUM_WORDS;
  localparam int unsigned IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_t;

  state_t              r_state,   w_state_nxt;
  logic [IDX_W-1:0]    r_idx,     w_idx_nxt;
  logic [HASH_W-1:0]   r_hash,    w_hash_nxt;
  logic                r_eq,      w_eq_nxt;
  logic                r_we,      w_we_nxt;
  logic [15:0]         r_addr,    w_addr_nxt;
  logic [31:0]         r_data,    w_data_nxt;
  logic                r_busy,    w_busy_nxt;
  logic                r_done,    w_done_nxt;
  logic                r_match,   w_match_nxt;
  logic                r_overrun, w_overrun_nxt;
  logic                w_unused;

  // Upper address bits are outside the 16-bit dpsram space.
  assign w_unused = ^output_addr[31:16];

  function automatic logic [31:0] f_swap(input logic [31:0] w);
    if (SWAP_BYTES) return {w[7:0], w[15:8], w[23:16], w[31:24]};
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_hash    <= '0;
      r_eq      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_match   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_hash    <= w_hash_nxt;
      r_eq      <= w_eq_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_match   <= w_match_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // The captured digest is kept as a shift register; its top word is always the next to write.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_hash_nxt    = r_hash;
    w_eq_nxt      = r_eq;
    w_we_nxt      = 1'b0;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_match_nxt   = r_match;
    w_overrun_nxt = r_overrun;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_WRITE;
          w_idx_nxt   = '0;
          w_hash_nxt  = {hash[HASH_W-33:0], 32'h0};
          w_eq_nxt    = compare_en && (hash == target_hash);
          w_we_nxt    = 1'b1;
          w_addr_nxt  = output_addr[15:0];
          w_data_nxt  = f_swap(hash[HASH_W-1 -: 32]);
          w_busy_nxt  = 1'b1;
          w_match_nxt = 1'b0;
        end
      end
      ST_WRITE: begin
        if (start) w_overrun_nxt = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_match_nxt = r_eq;
        end else begin
          w_idx_nxt  = r_idx + IDX_W'(1);
          w_hash_nxt = {r_hash[HASH_W-33:0], 32'h0};
          w_we_nxt   = 1'b1;
          w_addr_nxt = r_addr + 16'(ADDR_STRIDE);
          w_data_nxt = f_swap(r_hash[HASH_W-1 -: 32]);
          w_busy_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign port_A_clk     = clk;
  assign port_A_data_in = r_data;
  assign port_A_addr    = r_addr;
  assign port_A_we      = r_we;
  assign busy           = r_busy;
  assign done           = r_done;
  assign match          = r_match;
  assign overrun        = r_overrun;

endmodule
